iot_riscv_dbg_ctrl: RTL
=======================

# iot_riscv_dbg_ctrl

Run-control sequencer between the external debug host and the core's breakpoint/halt unit. It accepts halt, resume, step and clear commands over a valid/ready handshake. It drives the unit's pause and step inputs, watches the halt, data-halt, single-step and ebreak indications, and reports a registered halted status with a halt cause. It sits in the debug subsystem beside the breakpoint unit and is the only driver of `riscv_debug_pause` and `riscv_debug_step`.

## Interface
- `timeout_cycles_p`, 1024: cycles allowed in a wait state before a forced timeout halt; minimum 2.
- `main_clk_i`  in  1  core clock
- `main_rst_i`  in  1  reset, synchronous, active-high
- `cmd_valid_i`  in  1  host command valid
- `cmd_ready_o`  out  1  command accepted when valid & ready
- `cmd_i`  in  2  command: 0=HALT, 1=RESUME, 2=STEP, 3=CLEAR
- `debug_halt_i`  in  1  registered instruction-halt state of the breakpoint unit
- `debug_halt_data_i`  in  1  registered data-breakpoint halt state
- `debug_single_step_i`  in  1  single-step-in-progress flag
- `riscv_debug_break_i`  in  1  ebreak decoded in ID
- `riscv_debug_pause_o`  out  1  pause request to the breakpoint unit
- `riscv_debug_step_o`  out  1  one-cycle step/release pulse
- `halted_o`  out  1  core halted (state HALTED)
- `cause_o`  out  3  0=none, 1=pause, 2=instr bp, 3=data bp, 4=ebreak, 5=step, 6=timeout
- `halt_evt_o`  out  1  one-cycle pulse on entry to HALTED
- `cmd_err_o`  out  1  sticky: RESUME or STEP accepted while not halted

## Operation
- Reset: state RUN, all outputs 0, `cmd_ready_o`=0 during reset and 1 in the first cycle after reset.
- Every output is registered. `cmd_ready_o`=1 only in RUN and HALTED.
- **RUN:** checked in priority order.
  - `debug_halt_data_i` goes to HALTED with cause 3.
  - Otherwise `debug_halt_i` goes to HALTED with cause 2.
  - Otherwise `riscv_debug_break_i` sets pause=1 and goes to HALT_WAIT with pending cause 4.
  - Otherwise an accepted HALT sets pause=1 and goes to HALT_WAIT with pending cause 1.
  - Entering HALTED from RUN also sets pause=1.
  - RESUME or STEP in RUN is accepted, sets `cmd_err_o` and is otherwise ignored.
- **HALT_WAIT:** `debug_halt_i` | `debug_halt_data_i` goes to HALTED with the pending cause.
- **HALTED:**
  - HALT is a no-op.
  - RESUME clears pause and goes to RELEASE.
  - STEP keeps pause=1 and goes to STEP_PULSE.
- **RELEASE:** `riscv_debug_step_o`=1 for exactly one cycle, then RELEASE_WAIT.
- **RELEASE_WAIT:** waits for `debug_halt_i`=0 and `debug_halt_data_i`=0, then goes to RUN. Breakpoint sampling is masked until RUN is reached.
- **STEP_PULSE:** `riscv_debug_step_o`=1 for one cycle, then STEP_ARM.
- **STEP_ARM:** waits for `debug_single_step_i`=1, then STEP_WAIT.
- **STEP_WAIT:** waits for `debug_single_step_i`=0 and `debug_halt_i`=1, then HALTED with cause 5.
- **CLEAR:** accepted in RUN or HALTED. Clears `cmd_err_o` and `cause_o`. Does not change state or pause.
- `cause_o` is written only on HALTED entry or by CLEAR. It holds its value through RELEASE and RUN.

## Timing
- A command accepted in cycle N produces its output change in N+1. Example: HALT accepted in N gives pause=1 in N+1.
- Halt latency: the breakpoint unit registers pause in N+2. `halted_o` and `halt_evt_o` assert in N+3.
- Instruction breakpoint in RUN: `debug_halt_i` high in cycle M gives `halted_o`=1 and pause=1 in M+1.
- RESUME accepted in N: pause=0 in N+1, step pulse in N+2, RUN reached no earlier than N+4.
- A breakpoint condition in the same cycle as an accepted HALT takes the breakpoint cause. The command is still consumed.
- Reset asserted in any state returns to RUN on the next edge with pause=0. No step pulse is emitted.

## Configuration
- `IOT_RISCV_DBG_CTRL_TIMEOUT_EN` defined:
  - A counter of width $clog2(`timeout_cycles_p`+1) clears on entry to HALT_WAIT, STEP_ARM or STEP_WAIT and increments each cycle spent in those states.
  - When it reaches `timeout_cycles_p`, the block enters HALTED with cause 6, pause=1 and a `halt_evt_o` pulse.
- Undefined: no counter is built. The wait states wait indefinitely and cause 6 is never produced.

## Test plan
- Halt then resume:
  - HALT in RUN with `debug_halt_i` following pause one cycle later -> `halted_o`=1, `cause_o`=1, single `halt_evt_o`.
  - Then RESUME -> one `riscv_debug_step_o` pulse, pause=0, `halted_o`=0.
- Instruction breakpoint: `debug_halt_i` pulses high in RUN -> HALTED, `cause_o`=2, pause=1 next cycle.
- Simultaneous data and instruction halt: `debug_halt_data_i` and `debug_halt_i` both high -> `cause_o`=3.
- Single step:
  - STEP while halted, with `debug_single_step_i` high for 3 cycles and then `debug_halt_i` re-asserted -> exactly one step pulse, pause held at 1, HALTED with `cause_o`=5.
- Error and clear: RESUME in RUN -> `cmd_err_o`=1, state unchanged. CLEAR -> `cmd_err_o`=0, `cause_o`=0.
- Timeout (macro defined, `timeout_cycles_p`=8): HALT with `debug_halt_i` held at 0 -> HALTED with `cause_o`=6 after 8 cycles in HALT_WAIT.

Source files
------------

// File: rtl/iot_riscv_dbg_ctrl.sv
// Run-control sequencer between the debug host and the core's breakpoint/halt unit.
// Optional feature: define IOT_RISCV_DBG_CTRL_TIMEOUT_EN to force a halt when a wait state stalls.
module iot_riscv_dbg_ctrl #(
    parameter int unsigned timeout_cycles_p = 1024
) (
    input  logic       main_clk_i,
    input  logic       main_rst_i,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic [1:0] cmd_i,
    input  logic       debug_halt_i,
    input  logic       debug_halt_data_i,
    input  logic       debug_single_step_i,
    input  logic       riscv_debug_break_i,
    output logic       riscv_debug_pause_o,
    output logic       riscv_debug_step_o,
    output logic       halted_o,
    output logic [2:0] cause_o,
    output logic       halt_evt_o,
    output logic       cmd_err_o
);

    typedef enum logic [1:0] {CmdHalt, CmdResume, CmdStep, CmdClear} cmd_e;

    typedef enum logic [2:0] {
        StRun, StHaltWait, StHalted, StRelease, StReleaseWait, StStepPulse, StStepArm, StStepWait
    } state_e;

    localparam logic [2:0] CauseNone    = 3'd0;
    localparam logic [2:0] CausePause   = 3'd1;
    localparam logic [2:0] CauseInstr   = 3'd2;
    localparam logic [2:0] CauseData    = 3'd3;
    localparam logic [2:0] CauseEbreak  = 3'd4;
    localparam logic [2:0] CauseStep    = 3'd5;
    localparam logic [2:0] CauseTimeout = 3'd6;

    if (timeout_cycles_p < 2) begin : g_bad_timeout
        $error("timeout_cycles_p must be at least 2");
    end

    state_e     state;
    logic [2:0] pending;
    logic       cmd_acc;
    logic       timeout_hit;

    assign cmd_acc = cmd_valid_i & cmd_ready_o;

`ifdef IOT_RISCV_DBG_CTRL_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(timeout_cycles_p + 1);

    logic [CntW-1:0] cnt;
    logic            wait_st;
    logic            arm_done;

    assign wait_st     = (state == StHaltWait) || (state == StStepArm) || (state == StStepWait);
    assign arm_done    = (state == StStepArm) && debug_single_step_i;
    assign timeout_hit = wait_st && (cnt == CntW'(timeout_cycles_p - 1));

    // Outside the wait states the count sits at zero, so every entry starts fresh.
    always_ff @(posedge main_clk_i) begin
        if (main_rst_i || !wait_st || arm_done) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CntW'(1);
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge main_clk_i) begin
        if (main_rst_i) begin
            state               <= StRun;
            pending             <= CauseNone;
            cmd_ready_o         <= 1'b0;
            riscv_debug_pause_o <= 1'b0;
            riscv_debug_step_o  <= 1'b0;
            halted_o            <= 1'b0;
            cause_o             <= CauseNone;
            halt_evt_o          <= 1'b0;
            cmd_err_o           <= 1'b0;
        end else begin
            halt_evt_o         <= 1'b0;
            riscv_debug_step_o <= 1'b0;
            cmd_ready_o        <= 1'b0;
            unique case (state)
                StRun: begin
                    cmd_ready_o <= 1'b1;
                    if (cmd_acc && (cmd_i == CmdClear)) begin
                        cmd_err_o <= 1'b0;
                        cause_o   <= CauseNone;
                    end
                    if (cmd_acc && ((cmd_i == CmdResume) || (cmd_i == CmdStep))) begin
                        cmd_err_o <= 1'b1;
                    end
                    // Breakpoints outrank a concurrent command; the command is still consumed.
                    if (debug_halt_data_i || debug_halt_i) begin
                        state               <= StHalted;
                        cause_o             <= debug_halt_data_i ? CauseData : CauseInstr;
                        riscv_debug_pause_o <= 1'b1;
                        halted_o            <= 1'b1;
                        halt_evt_o          <= 1'b1;
                    end else if (riscv_debug_break_i) begin
                        state               <= StHaltWait;
                        pending             <= CauseEbreak;
                        riscv_debug_pause_o <= 1'b1;
                        cmd_ready_o         <= 1'b0;
                    end else if (cmd_acc && (cmd_i == CmdHalt)) begin
                        state               <= StHaltWait;
                        pending             <= CausePause;
                        riscv_debug_pause_o <= 1'b1;
                        cmd_ready_o         <= 1'b0;
                    end
                end
                StHaltWait: begin
                    if (debug_halt_i || debug_halt_data_i || timeout_hit) begin
                        state               <= StHalted;
                        cause_o             <= (debug_halt_i || debug_halt_data_i) ?
                                               pending : CauseTimeout;
                        riscv_debug_pause_o <= 1'b1;
                        halted_o            <= 1'b1;
                        halt_evt_o          <= 1'b1;
                        cmd_ready_o         <= 1'b1;
                    end
                end
                StHalted: begin
                    cmd_ready_o <= 1'b1;
                    if (cmd_acc) begin
                        unique case (cmd_i)
                            CmdResume: begin
                                state               <= StRelease;
                                riscv_debug_pause_o <= 1'b0;
                                halted_o            <= 1'b0;
                                cmd_ready_o         <= 1'b0;
                            end
                            CmdStep: begin
                                state       <= StStepPulse;
                                halted_o    <= 1'b0;
                                cmd_ready_o <= 1'b0;
                            end
                            CmdClear: begin
                                cmd_err_o <= 1'b0;
                                cause_o   <= CauseNone;
                            end
                            default: ;
                        endcase
                    end
                end
                StRelease: begin
                    riscv_debug_step_o <= 1'b1;
                    state              <= StReleaseWait;
                end
                StReleaseWait: begin
                    // Halt lines are ignored while the release pulse is still on the wire.
                    if (!riscv_debug_step_o && !debug_halt_i && !debug_halt_data_i) begin
                        state       <= StRun;
                        cmd_ready_o <= 1'b1;
                    end
                end
                StStepPulse: begin
                    riscv_debug_step_o <= 1'b1;
                    state              <= StStepArm;
                end
                StStepArm: begin
                    if (debug_single_step_i) begin
                        state <= StStepWait;
                    end else if (timeout_hit) begin
                        state       <= StHalted;
                        cause_o     <= CauseTimeout;
                        halted_o    <= 1'b1;
                        halt_evt_o  <= 1'b1;
                        cmd_ready_o <= 1'b1;
                    end
                end
                StStepWait: begin
                    if ((!debug_single_step_i && debug_halt_i) || timeout_hit) begin
                        state       <= StHalted;
                        cause_o     <= (!debug_single_step_i && debug_halt_i) ?
                                       CauseStep : CauseTimeout;
                        halted_o    <= 1'b1;
                        halt_evt_o  <= 1'b1;
                        cmd_ready_o <= 1'b1;
                    end
                end
                default: begin
                    state <= StRun;
                end
            endcase
        end
    end

endmodule
